mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
- Forward (encryption-side) MixColumns engine for the AES-256 encryption datapath.
- It is the counterpart of the existing decryption inverse-MixColumns helper.
- Accepts one 128-bit AES state over a valid/ready handshake and mixes it column by column, COLS_PER_CYCLE columns per cycle, using xtime arithmetic rather than lookup tables.
- Returns the result over a second valid/ready handshake. A per-block bypass flag supports the final round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per BUSY cycle. Legal values are 1, 2 and 4; any other value is a compile-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data and in_bypass are valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  AES state after ShiftRows.
- in_bypass  input  1  final round; pass the state through unmixed.
- out_valid  output  1  out_data holds a completed state.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  mixed (or bypassed) state.

Behaviour:
- Byte/column layout (FIPS-197):
  - Column c occupies bits [127-32c -: 32]; its row-0 byte is the MSB.
  - So in_data[127:120] = s(0,0) and in_data[7:0] = s(3,3).
- Column mix for input bytes a0..a3 (a0 = MSB):
  - r0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - r1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - r2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - r3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - 2x = xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00); 3x = xtime(x) ^ x. All arithmetic is 8-bit, GF(2^8).
- FSM states IDLE, BUSY, DONE; the state register holds the 128-bit working state plus a 2-bit column counter col.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load in_data into the working register and set col = 0.
  - Go to DONE if in_bypass = 1, otherwise to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, replace columns col .. col+COLS_PER_CYCLE-1 with their mixed values, then col += COLS_PER_CYCLE (mod 4).
  - When the last column group is written (col + COLS_PER_CYCLE == 4), go to DONE.
  - Columns not yet processed and columns already processed are untouched.
- DONE:
  - out_valid = 1 and out_data = working register.
  - On out_ready, go to IDLE.
  - out_data and out_valid stay stable while out_valid & !out_ready (backpressure held indefinitely).
- Latency, measured from the input-handshake edge to the first cycle out_valid is high:
  - Mix: 1 + 4/COLS_PER_CYCLE cycles, i.e. 5 for COLS_PER_CYCLE = 1, 3 for 2, 2 for 4.
  - Bypass: 1 cycle.
- Throughput: one state is in flight at a time. in_ready is low in BUSY and DONE, including the cycle in which the output handshake completes. The next accept is no earlier than the cycle after DONE exits.
- in_valid, in_data and in_bypass are ignored outside IDLE. Their values while in_ready = 0 have no effect.
- out_ready while not in DONE has no effect.
- Reset, including mid-BUSY or in DONE with a pending output:
  - Next state is IDLE, col = 0, working register = 0.
  - out_valid = 0, out_data = 128'h0, in_ready = 1 in the first cycle after reset deasserts.
  - Any in-flight state is discarded with no partial output.
- out_data is driven directly from the working register; there is no combinational path from in_data to out_data.

Decomposition:
- Shared package/header aes_pkg:
  - AES_STATE_W = 128 and AES_COL_W = 32;
  - the xtime function;
  - FSM state encodings for IDLE/BUSY/DONE.
- Sub-module mix_column_word: combinational, 32-bit in to 32-bit out, forward MixColumns for one column using aes_pkg xtime. Instantiated COLS_PER_CYCLE times.
- mix_columns_seq contains only the FSM, column counter, working register and column-select/write-back muxing.

Test Plan:
- FIPS-197 App. B round-1 vector: in_data = d4bf5d30_e0b452ae_b84111f1_1e2798e5, bypass = 0, out_ready = 1 -> out_data = 046681e5_e0cb199a_48f8d37a_2806264c, out_valid exactly 5 cycles after accept. Repeat with COLS_PER_CYCLE = 2 and 4 for 3 and 2 cycles, same data.
- Per-column identities: columns db135345 / f20a225c / 01010101 / c6c6c6c6 packed into one state -> out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Bypass: in_bypass = 1, in_data = 00112233_44556677_8899aabb_ccddeeff -> identical out_data, out_valid 1 cycle after accept.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready = 0 throughout; in_valid pulses with other data during this window are not accepted. Release out_ready -> single transfer, then in_ready = 1 the next cycle.
- Reset mid-operation: assert rst in the second BUSY cycle -> the next cycle shows out_valid = 0, out_data = 0, in_ready = 1; a new state then produces the correct result with normal latency.
- Back-to-back: in_valid held high with three different states and out_ready = 1 -> three correct outputs in order, each accepted only when in_ready = 1, with no accepts during BUSY/DONE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column widths, GF(2^8) xtime helper and the
// MixColumns engine state encoding.
package aes_pkg;

    localparam int unsigned AES_STATE_W  = 128;
    localparam int unsigned AES_COL_W    = 32;
    localparam int unsigned AES_NUM_COLS = AES_STATE_W / AES_COL_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mc_state_e;

    // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward MixColumns on a single 32-bit column; row-0 byte is the MSB.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3a = xtime(a) ^ a, so each row folds the 3x term into its xtime plus the plain byte.
    assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential forward MixColumns: one AES state in flight, COLS_PER_CYCLE columns
// mixed per busy cycle, optional bypass for the final round.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Column index holding the final group; reaching it ends the busy phase.
    localparam logic [1:0] LAST_COL = 2'(AES_NUM_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    mc_state_e              state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic [AES_STATE_W-1:0] work_q, work_d;

    logic [1:0]           lane_idx [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] lane_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] lane_out [COLS_PER_CYCLE];

    // Column c sits at bit offset 32*(3-c); for a 2-bit c that is {~c, 5'b0}.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign lane_idx[g] = col_q + 2'(g);
        assign lane_in[g]  = work_q[{~lane_idx[g], 5'd0} +: AES_COL_W];

        mix_column_word u_mix_column_word (
            .col_in  (lane_in[g]),
            .col_out (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= 2'd0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_data;
                    col_d   = 2'd0;
                    state_d = in_bypass ? StDone : StBusy;
                end
            end
            StBusy: begin
                for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_d[{~lane_idx[i], 5'd0} +: AES_COL_W] = lane_out[i];
                end
                col_d = col_q + COL_STEP;
                if (col_q == LAST_COL) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign out_data = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: one instance per legal COLS_PER_CYCLE,
// exercised in turn and checked against a GF(2^8) matrix-product model.
module tb_mix_columns_seq;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] ID_IN    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] ID_OUT   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_bypass;
    logic         out_ready;
    logic [127:0] in_data;

    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic [127:0] out_data_a  [3];

    int           sel;
    logic         in_ready_m;
    logic         out_valid_m;
    logic [127:0] out_data_m;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           lat_q [$];
    bit           lat_done = 1'b0;
    logic [127:0] pend_exp;
    int           pend_lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid && (sel == g)),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data),
            .in_bypass (in_bypass),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready && (sel == g)),
            .out_data  (out_data_a[g])
        );
    end

    assign in_ready_m  = in_ready_a[sel];
    assign out_valid_m = out_valid_a[sel];
    assign out_data_m  = out_data_a[sel];

    // Reference: generic shift-and-add GF(2^8) multiply and a circulant matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        logic [7:0] acc = 8'h00;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) acc = acc ^ p;
            p = (p[7] == 1'b1) ? (8'((p << 1)) ^ 8'h1b) : 8'(p << 1);
        end
        return acc;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] st);
        int           coef [4] = '{2, 3, 1, 1};
        logic [7:0]   s [4][4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[c][r] = st[127 - 32 * c - 8 * r -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(s[c][k], coef[(k - r + 4) % 4]);
                res[127 - 32 * c - 8 * r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int cpc_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cpc=%0d t=%0t): got %h expected %h",
                     name, cpc_of(sel), $time, act, exp);
        end
    endtask

    // Monitor: records accepts into the scoreboard and checks every completed output.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
            lat_done = 1'b0;
        end else begin
            if (out_valid_m) begin
                if (exp_q.size() == 0) begin
                    if (out_ready) check("unexpected output", 128'(out_valid_m), 128'(0));
                end else begin
                    if (!lat_done) begin
                        check("latency", 128'(cyc - acc_q[0] + 1), 128'(lat_q[0]));
                        lat_done = 1'b1;
                    end
                    if (out_ready) begin
                        check("out_data", out_data_m, exp_q[0]);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(lat_q.pop_front());
                        lat_done = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready_m) begin
                exp_q.push_back(pend_exp);
                acc_q.push_back(cyc + 1);
                lat_q.push_back(pend_lat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic b, input logic [127:0] e,
                        input bit drop);
        bit ok = 1'b0;
        pend_exp  = e;
        pend_lat  = b ? 1 : 1 + 4 / cpc_of(sel);
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready_m) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept timeout", 128'(0), 128'(1));
        tick();
        if (drop) in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd_ready);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid_m) begin
                ok = 1'b1;
                break;
            end
            if (rnd_ready) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        if (!ok) check("drain timeout", 128'(0), 128'(1));
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        bit           ok;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        sel       = 0;
        pend_exp  = '0;
        pend_lat  = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset out_valid", 128'(out_valid_a[s]), 128'(0));
            check("reset out_data", out_data_a[s], 128'(0));
            check("reset in_ready", 128'(in_ready_a[s]), 128'(1));
        end
        tick();

        for (int s = 0; s < 3; s++) begin
            sel = s;

            send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
            drain(1'b0);
            send(ID_IN, 1'b0, ID_OUT, 1'b1);
            drain(1'b0);
            send(BYP_IN, 1'b1, BYP_IN, 1'b1);
            drain(1'b0);

            // Backpressure: hold DONE, poke in_valid with other data, then release.
            out_ready = 1'b0;
            d = rand128();
            send(d, 1'b0, mix_ref(d), 1'b1);
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (out_valid_m) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("bp out_valid timeout", 128'(0), 128'(1));
            held = out_data_m;
            tick();
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("bp out_valid", 128'(out_valid_m), 128'(1));
                check("bp out_data", out_data_m, held);
                check("bp in_ready", 128'(in_ready_m), 128'(0));
                tick();
                in_valid = (k % 2 == 0);
                in_data  = rand128();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check("bp handshake in_ready", 128'(in_ready_m), 128'(0));
            @(negedge clk);
            check("bp after out_valid", 128'(out_valid_m), 128'(0));
            check("bp after in_ready", 128'(in_ready_m), 128'(1));
            tick();

            // Reset during the second BUSY cycle discards the block.
            d = rand128();
            send(d, 1'b0, mix_ref(d), 1'b1);
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            @(negedge clk);
            check("midreset out_valid", 128'(out_valid_m), 128'(0));
            check("midreset out_data", out_data_m, 128'(0));
            check("midreset in_ready", 128'(in_ready_m), 128'(1));
            tick();
            d = rand128();
            send(d, 1'b0, mix_ref(d), 1'b1);
            drain(1'b0);

            // Back-to-back with in_valid held high.
            for (int i = 0; i < 3; i++) begin
                d = rand128();
                send(d, 1'b0, mix_ref(d), i == 2);
            end
            drain(1'b0);

            // Random states, occasional bypass, random output stalls.
            for (int i = 0; i < 20; i++) begin
                logic b;
                d = rand128();
                b = ($urandom_range(0, 4) == 0);
                send(d, b, b ? d : mix_ref(d), 1'b1);
                drain(1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
